// File: rtl/bcd_cascade_counter_if.sv
// Control/status bundle for bcd_cascade_counter.
//   master: drives clr, load, load_val, ena, up; observes q, tc, ovf
//   slave : the counter itself
// DIGITS must match the counter instance; load_val and q carry digit i
// at bits [4i+3:4i].
interface bcd_cascade_counter_if #(
  parameter int DIGITS = 3
);
  logic                  clr;
  logic                  load;
  logic [4*DIGITS-1:0]   load_val;
  logic                  ena;
  logic                  up;
  logic [4*DIGITS-1:0]   q;
  logic                  tc;
  logic                  ovf;

  modport master (output clr, load, load_val, ena, up,
                  input  q, tc, ovf);
  modport slave  (input  clr, load, load_val, ena, up,
                  output q, tc, ovf);
endinterface

// File: rtl/bcd_cascade_counter.sv
// Multi-digit modulo-RADIX up/down counter with synchronous ripple carry.
//   clk, reset_n : clock, asynchronous active-low reset (q=0, ovf=0)
//   bus (slave)  : clr > load > ena > hold; up selects direction;
//                  q = digits, tc = combinational terminal count,
//                  ovf = registered one-cycle wrap pulse.
// Build option BCD_CASCADE_SAT_EN: saturate instead of wrapping; ovf
// pulses only on the first saturating attempt (sticky flag).

// One digit: register plus its own step/load logic.
module bcd_cascade_digit #(
  parameter int RADIX = 10
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       step,
  input  logic       up,
  output logic [3:0] d,
  output logic       at_max,
  output logic       at_zero
);
  localparam logic [4:0] RAD  = 5'(RADIX);
  localparam logic [3:0] DMAX = 4'(RADIX - 1);

  logic [3:0] d_step;

  // Out-of-range digits recover to 0 on any step, in either direction.
  always_comb begin
    d_step = d;
    if ({1'b0, d} >= RAD) d_step = '0;
    else if (up)          d_step = (d == DMAX)  ? 4'd0 : d + 4'd1;
    else                  d_step = (d == 4'd0)  ? DMAX : d - 4'd1;
  end

  assign at_max  = (d == DMAX);
  assign at_zero = (d == 4'd0);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  d <= '0;
    else if (clr)  d <= '0;
    else if (load) d <= ({1'b0, ld_val} >= RAD) ? 4'd0 : ld_val;
    else if (step) d <= d_step;
  end
endmodule

module bcd_cascade_counter #(
  parameter int DIGITS = 3,
  parameter int RADIX  = 10
) (
  input logic                   clk,
  input logic                   reset_n,
  bcd_cascade_counter_if.slave  bus
);
  logic [DIGITS-1:0][3:0] dig;
  logic [DIGITS-1:0]      at_max, at_zero;
  logic [DIGITS:0]        chain;   // chain[i]: all digits below i at their limit
  logic                   tc, hold, ovf_q;

  assign chain[0] = 1'b1;

  generate
    for (genvar i = 0; i < DIGITS; i++) begin : g_dig
      assign chain[i+1] = chain[i] & (bus.up ? at_max[i] : at_zero[i]);
      bcd_cascade_digit #(.RADIX(RADIX)) u_dig (
        .clk     (clk),
        .reset_n (reset_n),
        .clr     (bus.clr),
        .load    (bus.load),
        .ld_val  (bus.load_val[4*i +: 4]),
        .step    (bus.ena & chain[i] & ~hold),
        .up      (bus.up),
        .d       (dig[i]),
        .at_max  (at_max[i]),
        .at_zero (at_zero[i])
      );
    end
  endgenerate

  // chain[DIGITS] is "every digit at the limit for this direction".
  assign tc = bus.ena & chain[DIGITS];

`ifdef BCD_CASCADE_SAT_EN
  logic sat_q;

  // At the limit the whole counter freezes instead of wrapping.
  assign hold = tc;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else if (bus.clr || bus.load) begin
      sat_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      ovf_q <= tc & ~sat_q;
      // A real step (ena without tc) means we left the limit.
      if (tc)           sat_q <= 1'b1;
      else if (bus.ena) sat_q <= 1'b0;
    end
  end
`else
  assign hold = 1'b0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= tc & ~bus.clr & ~bus.load;
  end
`endif

  assign bus.q   = dig;
  assign bus.tc  = tc;
  assign bus.ovf = ovf_q;
endmodule

// File: tb/tb_bcd_cascade_counter.sv
// Directed bench for bcd_cascade_counter, DIGITS=3, RADIX=10.
// Inputs change 1ns after the rising edge; outputs are checked there too.
module tb_bcd_cascade_counter;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_tests = 0;
  int   n_fail  = 0;

  bcd_cascade_counter_if #(.DIGITS(3)) bus ();

  bcd_cascade_counter #(.DIGITS(3), .RADIX(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_load(input logic [11:0] v);
    bus.load = 1'b1; bus.load_val = v; bus.ena = 1'b0;
    tick();
    bus.load = 1'b0;
  endtask

  initial begin
    bus.clr = 1'b0; bus.load = 1'b0; bus.load_val = '0;
    bus.ena = 1'b0; bus.up = 1'b1;
    #3;
    check("rst_q",   32'(bus.q),   32'h000);
    check("rst_ovf", 32'(bus.ovf), 0);
    check("rst_tc",  32'(bus.tc),  0);
    #10 reset_n = 1'b1;
    tick();

    // Reset between edges while counting.
    do_load(12'h457);
    check("ld_457", 32'(bus.q), 32'h457);
    #2 reset_n = 1'b0;
    #1;
    check("amid_rst_q",   32'(bus.q),   32'h000);
    check("amid_rst_ovf", 32'(bus.ovf), 0);
    #1 reset_n = 1'b1;
    bus.ena = 1'b1; bus.up = 1'b1;
    tick();
    check("post_rst_cnt", 32'(bus.q), 32'h001);
    bus.ena = 1'b0;

    // Up carry chain.
    do_load(12'h099);
    bus.ena = 1'b1; bus.up = 1'b1;
    #1 check("carry_tc0", 32'(bus.tc), 0);
    tick();
    check("carry_100", 32'(bus.q), 32'h100);
    check("carry_tc1", 32'(bus.tc), 0);
    tick();
    check("carry_101", 32'(bus.q), 32'h101);
    bus.ena = 1'b0;

    // Load beats ena even at terminal count: no ovf.
    do_load(12'h999);
    bus.load = 1'b1; bus.load_val = 12'h321; bus.ena = 1'b1; bus.up = 1'b1;
    #1 check("ldtc_tc", 32'(bus.tc), 1);
    tick();
    check("ldtc_q",   32'(bus.q),   32'h321);
    check("ldtc_ovf", 32'(bus.ovf), 0);
    bus.load = 1'b0; bus.ena = 1'b0;

`ifndef BCD_CASCADE_SAT_EN
    // Up wrap.
    do_load(12'h999);
    bus.ena = 1'b1; bus.up = 1'b1;
    #1 check("upw_tc", 32'(bus.tc), 1);
    tick();
    check("upw_q",   32'(bus.q),   32'h000);
    check("upw_ovf", 32'(bus.ovf), 1);
    bus.ena = 1'b0;
    tick();
    check("upw_ovf_end", 32'(bus.ovf), 0);

    // Down borrow and wrap.
    do_load(12'h100);
    bus.ena = 1'b1; bus.up = 1'b0;
    tick();
    check("dn_099", 32'(bus.q), 32'h099);
    do_load(12'h000);
    bus.ena = 1'b1; bus.up = 1'b0;
    #1 check("dnw_tc", 32'(bus.tc), 1);
    tick();
    check("dnw_q",   32'(bus.q),   32'h999);
    check("dnw_ovf", 32'(bus.ovf), 1);
    bus.ena = 1'b0;
    tick();
    check("dnw_ovf_end", 32'(bus.ovf), 0);
`endif

    // Illegal digits on load, with ena also asserted.
    bus.load = 1'b1; bus.load_val = 12'h9AF; bus.ena = 1'b1; bus.up = 1'b1;
    tick();
    check("ld_illegal", 32'(bus.q), 32'h900);
    bus.clr = 1'b1; bus.load_val = 12'h555;
    tick();
    check("clr_over_ld", 32'(bus.q), 32'h000);
    bus.clr = 1'b0; bus.ena = 1'b0;
    do_load(12'h123);
    repeat (5) tick();
    check("hold_5", 32'(bus.q), 32'h123);

`ifdef BCD_CASCADE_SAT_EN
    do_load(12'h998);
    bus.ena = 1'b1; bus.up = 1'b1;
    tick();
    check("sat_q1", 32'(bus.q),   32'h999);
    check("sat_o1", 32'(bus.ovf), 0);
    tick();
    check("sat_q2", 32'(bus.q),   32'h999);
    check("sat_o2", 32'(bus.ovf), 1);
    tick();
    check("sat_q3", 32'(bus.q),   32'h999);
    check("sat_o3", 32'(bus.ovf), 0);
    tick();
    check("sat_q4", 32'(bus.q),   32'h999);
    check("sat_o4", 32'(bus.ovf), 0);
    bus.up = 1'b0;
    tick();
    check("sat_dn", 32'(bus.q), 32'h998);
    bus.ena = 1'b0;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/bcd_cascade_counter.md
Name: bcd_cascade_counter

Overview:
- Parametrised multi-digit modulo-RADIX counter. It is the successor to the single-digit slow-enable decade counter.
- Digits ripple-carry synchronously, in a single clock domain.
- Adds up/down counting, synchronous load, synchronous clear, a terminal-count flag and a registered overflow pulse.
- Used for timers, event tallies and 7-segment display front-ends.

Parameters:
- DIGITS, 3, number of cascaded digits (1..8); q width is 4*DIGITS.
- RADIX, 10, modulus of every digit (2..16); each digit counts 0..RADIX-1.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- clr  input  1  synchronous clear to all zeros; highest synchronous priority.
- load  input  1  synchronous parallel load of load_val.
- load_val  input  4*DIGITS  load value, digit i at bits [4i+3:4i].
- ena  input  1  count enable (slow enable); one step per clk with ena=1.
- up  input  1  direction: 1 = increment, 0 = decrement.
- q  output  4*DIGITS  counter value, digit 0 is least significant.
- tc  output  1  combinational terminal count.
- ovf  output  1  registered one-cycle wrap pulse.

Behaviour:
- Reset: reset_n=0 asynchronously forces q=0 and ovf=0, independent of clk. q and ovf are held at 0 while reset_n is low; counting resumes on the first clk edge after reset_n rises.
- Synchronous priority per edge: clr > load > ena > hold.
- clr=1: q <= 0, ovf <= 0.
- load=1 (clr=0): each digit <= load_val digit. Any loaded digit >= RADIX is stored as 0. ovf <= 0. ena is ignored that cycle.
- ena=1 with up=1:
  - Digit 0 increments.
  - Digit i steps only if all lower digits are at RADIX-1.
  - A stepping digit at RADIX-1 wraps to 0.
- ena=1 with up=0:
  - Digit 0 decrements.
  - Digit i steps only if all lower digits are 0.
  - A stepping digit at 0 wraps to RADIX-1.
- Out-of-range recovery: a digit found >= RADIX (unreachable in normal operation) goes to 0 on its next step regardless of direction.
- ena=0: q holds; ovf <= 0.
- tc = ena & (up ? all digits == RADIX-1 : all digits == 0). It is combinational, so the wrap happens on the edge where tc=1.
- ovf <= tc & ~clr & ~load. It is high for exactly one cycle after the wrap edge.
- Latency: q updates one edge after ena/load/clr; ovf lags the wrap edge by 0 cycles (registered with q).
- Direction change takes effect on the same edge as up is sampled; there is no pipeline.
- Simultaneous load and ena: load wins and no count occurs.
- Simultaneous clr and load: clr wins.

Optional Feature:
- Macro: BCD_CASCADE_SAT_EN.
- Defined (saturating mode):
  - When tc would fire, q holds at all-(RADIX-1) when counting up, or all-0 when counting down.
  - ovf pulses once on the first saturating attempt, then stays 0 while the counter remains saturated.
  - A sticky internal flag is cleared by clr, load, reset_n, or a step in the opposite direction.
- Not defined: wrap-around behaviour as above, with no sticky flag logic present.

Test Plan:
(DIGITS=3, RADIX=10, wrap build unless stated)
- Reset mid-count: assert reset_n=0 between edges at q=0x457 -> q=0x000 and ovf=0 immediately; first count after release gives q=0x001.
- Up carry chain: load 0x099, then ena=1, up=1 for 2 edges -> 0x100, then 0x101; tc=0 throughout.
- Up wrap: load 0x999, ena=1, up=1 -> tc=1 before the edge; after the edge q=0x000 and ovf=1 for one cycle, then ovf=0.
- Down borrow and wrap: load 0x100, up=0, ena=1 -> 0x099; then load 0x000 -> tc=1; next edge gives q=0x999 and ovf=1.
- Priority and illegal load:
  - load_val=0x9AF with load=1 and ena=1 -> q=0x900 (digits A and F forced to 0).
  - clr=1 together with load=1 -> q=0x000.
  - ena=0 for 5 edges -> q unchanged.
- Saturating build (BCD_CASCADE_SAT_EN): load 0x998, up=1, ena=1 for 4 edges -> 0x999, then 0x999 with ovf=1, then 0x999 with ovf=0 twice; then up=0 -> 0x998.
